// File: rtl/cpu_debug_slave_sysclk_cmdq.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : cpu_debug_slave_sysclk_cmdq
// Purpose : System-clock half of the JTAG debug slave; synchronises the
//           update strobes, queues DR captures and decodes popped commands.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module cpu_debug_slave_sysclk_cmdq #(
    parameter int DR_W        = 38,
    parameter int IR_W        = 2,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ACT_BIT     = 34,
    parameter int CNT_W       = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     vs_uir,
    input  logic                     vs_udr,
    input  logic [IR_W-1:0]          ir_in,
    input  logic [DR_W-1:0]          sr,
    input  logic                     cmd_ready,
    input  logic                     clr_overflow,
    output logic                     cmd_valid,
    output logic [IR_W-1:0]          cmd_ir,
    output logic [DR_W-1:0]          cmd_data,
    output logic [DR_W-1:0]          jdo,
    output logic [(2**IR_W)-1:0]     take_action,
    output logic [(2**IR_W)-1:0]     take_no_action,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_count,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int C_NACT  = 2**IR_W;
    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_LVL_W = C_PTR_W + 1;
    localparam int C_ENT_W = IR_W + DR_W;

    // Strobe index 0 = update-IR, 1 = update-DR
    logic [1:0]                    w_raw;
    logic [1:0][SYNC_STAGES-1:0]   r_sync;
    logic [1:0]                    r_dly;
    logic [1:0]                    r_armed;
    logic [SYNC_STAGES-1:0]        r_settle;
    logic [1:0]                    w_sync_out;
    logic [1:0]                    w_edge;
    logic                          w_settled;

    assign w_raw      = {vs_udr, vs_uir};
    assign w_sync_out = {r_sync[1][SYNC_STAGES-1], r_sync[0][SYNC_STAGES-1]};
    assign w_settled  = r_settle[SYNC_STAGES-1];
    assign w_edge     = w_sync_out & ~r_dly & r_armed;

    // Arming waits until the chain holds a real post-reset sample, so a strobe
    // held high through reset release is never mistaken for a fresh update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync   <= '0;
            r_dly    <= '0;
            r_armed  <= '0;
            r_settle <= '0;
        end else begin
            r_settle <= {r_settle[SYNC_STAGES-2:0], 1'b1};
            for (int s = 0; s < 2; s++) begin
                r_sync[s] <= {r_sync[s][SYNC_STAGES-2:0], w_raw[s]};
            end
            r_dly   <= w_sync_out;
            r_armed <= r_armed | ({2{w_settled}} & ~w_sync_out);
        end
    end

    logic [IR_W-1:0] r_ir_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ir_q <= '0;
        end else if (w_edge[0]) begin
            r_ir_q <= ir_in;
        end
    end

    logic [C_ENT_W-1:0] r_mem [DEPTH];
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [C_LVL_W-1:0] r_level;
    logic [C_ENT_W-1:0] w_head;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_push_ok;
    logic               w_drop;
    logic [C_NACT-1:0]  w_onehot;

    assign w_head    = r_mem[r_rd_ptr];
    assign w_full    = (r_level == C_LVL_W'(DEPTH));
    assign cmd_valid = (r_level != '0);
    assign cmd_ir    = cmd_valid ? w_head[C_ENT_W-1:DR_W] : '0;
    assign cmd_data  = cmd_valid ? w_head[DR_W-1:0] : '0;
    assign w_pop     = cmd_valid & cmd_ready;
    assign w_push    = w_edge[1];
    // A pop in the same cycle frees the slot, so a push into a full queue is kept
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_drop    = w_push & w_full & ~w_pop;
    assign w_onehot  = C_NACT'(1) << cmd_ir;

    // r_ir_q is the pre-update value when UIR and UDR edges coincide
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= {r_ir_q, sr};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_level <= r_level + C_LVL_W'(1);
                2'b01:   r_level <= r_level - C_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    logic [DR_W-1:0]   r_jdo;
    logic [C_NACT-1:0] r_take_action;
    logic [C_NACT-1:0] r_take_no_action;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_jdo            <= '0;
            r_take_action    <= '0;
            r_take_no_action <= '0;
        end else begin
            if (w_pop) r_jdo <= cmd_data;
            r_take_action    <= (w_pop &&  cmd_data[ACT_BIT]) ? w_onehot : '0;
            r_take_no_action <= (w_pop && !cmd_data[ACT_BIT]) ? w_onehot : '0;
        end
    end

    logic             r_overflow;
    logic [CNT_W-1:0] r_drop_count;

    // A drop coinciding with a clear restarts the count at one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (clr_overflow)
                r_drop_count <= CNT_W'(1);
            else if (r_drop_count != {CNT_W{1'b1}})
                r_drop_count <= r_drop_count + CNT_W'(1);
        end else if (clr_overflow) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end
    end

    assign jdo            = r_jdo;
    assign take_action    = r_take_action;
    assign take_no_action = r_take_no_action;
    assign overflow       = r_overflow;
    assign drop_count     = r_drop_count;
    assign level          = r_level;

endmodule
`default_nettype wire

// File: tb/tb_cpu_debug_slave_sysclk_cmdq.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_cpu_debug_slave_sysclk_cmdq
// Purpose : Directed self-checking bench for the sysclk command queue.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_cpu_debug_slave_sysclk_cmdq;

    logic        clk = 1'b0;
    logic        reset;
    logic        vs_uir, vs_udr;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic        cmd_ready, clr_overflow;
    logic        cmd_valid;
    logic [1:0]  cmd_ir;
    logic [37:0] cmd_data, jdo;
    logic [3:0]  take_action, take_no_action;
    logic        overflow;
    logic [7:0]  drop_count;
    logic [2:0]  level;

    int n_pass  = 0;
    int n_total = 0;

    logic [37:0] v3 [6];
    logic [37:0] v4 [5];

    cpu_debug_slave_sysclk_cmdq dut (
        .clk            (clk),
        .reset          (reset),
        .vs_uir         (vs_uir),
        .vs_udr         (vs_udr),
        .ir_in          (ir_in),
        .sr             (sr),
        .cmd_ready      (cmd_ready),
        .clr_overflow   (clr_overflow),
        .cmd_valid      (cmd_valid),
        .cmd_ir         (cmd_ir),
        .cmd_data       (cmd_data),
        .jdo            (jdo),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .level          (level)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic pulse_uir(input logic [1:0] ir);
        ir_in  = ir;
        vs_uir = 1'b1;
        repeat (3) tick();
        vs_uir = 1'b0;
        repeat (4) tick();
    endtask

    task automatic push_udr(input logic [37:0] val);
        sr     = val;
        vs_udr = 1'b1;
        repeat (3) tick();
        vs_udr = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        v3[0] = 38'h0_0000_0A01; v3[1] = 38'h4_0000_0A02; v3[2] = 38'h0_0000_0A03;
        v3[3] = 38'h4_0000_0A04; v3[4] = 38'h0_0000_0A05; v3[5] = 38'h4_0000_0A06;
        v4[0] = 38'h1_2345_6789; v4[1] = 38'h0_0BAD_F00D; v4[2] = 38'h4_CAFE_0001;
        v4[3] = 38'h3_0000_0003; v4[4] = 38'h2_5555_AAAA;

        reset = 1'b1; vs_uir = 1'b0; vs_udr = 1'b0; ir_in = '0; sr = '0;
        cmd_ready = 1'b0; clr_overflow = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 64'(cmd_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_jdo", 64'(jdo), 64'd0);
        chk("rst_act", 64'({take_action, take_no_action}), 64'd0);
        chk("rst_ovf", 64'({overflow, drop_count}), 64'd0);
        reset = 1'b0;
        repeat (5) tick();

        // Action command on ir 0, with latency check
        pulse_uir(2'd0);
        sr = 38'h4_0000_1234;
        vs_udr = 1'b1;
        tick();
        chk("lat_k", 64'(cmd_valid), 64'd0);
        tick();
        chk("lat_k1", 64'(cmd_valid), 64'd0);
        tick();
        chk("lat_k2", 64'(cmd_valid), 64'd1);
        chk("t1_ir", 64'(cmd_ir), 64'd0);
        chk("t1_data", 64'(cmd_data), 64'h4_0000_1234);
        vs_udr = 1'b0;
        cmd_ready = 1'b1;
        tick();
        chk("t1_jdo", 64'(jdo), 64'h4_0000_1234);
        chk("t1_act", 64'(take_action), 64'b0001);
        chk("t1_noact", 64'(take_no_action), 64'd0);
        chk("t1_level", 64'(level), 64'd0);
        tick();
        chk("t1_act_end", 64'(take_action), 64'd0);
        cmd_ready = 1'b0;
        repeat (4) tick();

        // No-action command on ir 2
        pulse_uir(2'd2);
        cmd_ready = 1'b1;
        sr = 38'h0_0000_5678;
        vs_udr = 1'b1;
        repeat (3) tick();
        chk("t2_valid", 64'(cmd_valid), 64'd1);
        tick();
        chk("t2_noact", 64'(take_no_action), 64'b0100);
        chk("t2_act", 64'(take_action), 64'd0);
        chk("t2_jdo", 64'(jdo), 64'h0_0000_5678);
        vs_udr = 1'b0;
        tick();
        chk("t2_noact_end", 64'(take_no_action), 64'd0);
        cmd_ready = 1'b0;
        repeat (4) tick();

        // Overfill: six updates into a four-entry queue
        for (int i = 0; i < 6; i++) push_udr(v3[i]);
        chk("t3_level", 64'(level), 64'd4);
        chk("t3_ovf", 64'(overflow), 64'd1);
        chk("t3_drops", 64'(drop_count), 64'd2);
        chk("t3_ir", 64'(cmd_ir), 64'd2);
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_head%0d", i), 64'(cmd_data), 64'(v3[i]));
            tick();
            chk($sformatf("t3_jdo%0d", i), 64'(jdo), 64'(v3[i]));
        end
        chk("t3_empty", 64'(level), 64'd0);
        tick();
        chk("empty_pop", 64'({take_action, take_no_action, cmd_valid}), 64'd0);
        cmd_ready = 1'b0;
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("t3_clr", 64'({overflow, drop_count}), 64'd0);

        // Push into a full queue while popping
        for (int i = 0; i < 4; i++) push_udr(v4[i]);
        chk("t4_full", 64'(level), 64'd4);
        sr = v4[4];
        vs_udr = 1'b1;
        repeat (2) tick();
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        vs_udr = 1'b0;
        chk("t4_level", 64'(level), 64'd4);
        chk("t4_ovf", 64'({overflow, drop_count}), 64'd0);
        chk("t4_jdo", 64'(jdo), 64'(v4[0]));
        chk("t4_head", 64'(cmd_data), 64'(v4[1]));
        repeat (4) tick();
        cmd_ready = 1'b1;
        repeat (4) tick();
        cmd_ready = 1'b0;
        chk("t4_last", 64'(jdo), 64'(v4[4]));
        chk("t4_drained", 64'(level), 64'd0);

        // Clear coincident with a drop
        for (int i = 0; i < 5; i++) push_udr(v4[i]);
        chk("t6_pre_drops", 64'(drop_count), 64'd1);
        sr = v4[0];
        vs_udr = 1'b1;
        repeat (2) tick();
        clr_overflow = 1'b1;
        tick();
        chk("t6_drop_wins", 64'({overflow, drop_count}), {55'd0, 1'b1, 8'd1});
        vs_udr = 1'b0;
        tick();
        clr_overflow = 1'b0;
        chk("t6_clr_alone", 64'({overflow, drop_count}), 64'd0);
        chk("t6_level", 64'(level), 64'd4);
        repeat (4) tick();

        // Reset mid-operation with update-DR held high across release
        vs_udr = 1'b1;
        sr = 38'h0_0000_0777;
        reset = 1'b1;
        tick();
        chk("t5_rst", 64'({cmd_valid, level, overflow, drop_count}), 64'd0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (6) tick();
        chk("t5_held", 64'(level), 64'd0);
        vs_udr = 1'b0;
        repeat (4) tick();
        vs_udr = 1'b1;
        repeat (3) tick();
        chk("t5_one", 64'(level), 64'd1);
        repeat (4) tick();
        vs_udr = 1'b0;
        repeat (5) tick();
        chk("t5_only_one", 64'(level), 64'd1);
        chk("t5_data", 64'(cmd_data), 64'h0_0000_0777);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_debug_slave_sysclk_cmdq.md
Name: cpu_debug_slave_sysclk_cmdq

Overview:
- System-clock half of the JTAG debug slave, parametrised and extended beyond the fixed-width sysclk decoder.
- Synchronises the virtual-JTAG update strobes (vs_uir, vs_udr) from the tck domain and latches the instruction register.
- Captures the data shift register into a command FIFO of configurable depth, so back-to-back JTAG updates are not lost while the CPU-side consumer is busy.
- Decodes each popped command into per-instruction take_action / take_no_action pulses, with overflow accounting.

Parameters:
- DR_W, 38: data shift register width.
- IR_W, 2: instruction register width; the action vectors are 2**IR_W wide.
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- SYNC_STAGES, 2: synchroniser flops per strobe; minimum 2.
- ACT_BIT, 34: bit index of sr that selects action versus no-action.
- CNT_W, 8: drop counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- vs_uir  in  1  update-IR level from tck domain; asynchronous to clk
- vs_udr  in  1  update-DR level from tck domain; asynchronous to clk
- ir_in  in  IR_W  instruction register; quasi-static while vs_uir is high
- sr  in  DR_W  data shift register; quasi-static while vs_udr is high
- cmd_ready  in  1  consumer accepts head command
- clr_overflow  in  1  clears overflow and drop_count
- cmd_valid  out  1  FIFO non-empty
- cmd_ir  out  IR_W  head entry instruction
- cmd_data  out  DR_W  head entry data
- jdo  out  DR_W  data of last popped command
- take_action  out  2**IR_W  one-cycle pulse on pop, ir==i and data[ACT_BIT]=1
- take_no_action  out  2**IR_W  one-cycle pulse on pop, ir==i and data[ACT_BIT]=0
- overflow  out  1  sticky: an update was dropped because the FIFO was full
- drop_count  out  CNT_W  saturating count of dropped updates
- level  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset values: all outputs 0; FIFO empty; ir_q=0; synchroniser chains 0; armed=0.
- Synchroniser:
  - Each strobe passes through SYNC_STAGES flops and then one delay flop d.
  - Edge = sync_out & ~d.
- Arming:
  - Each strobe has an armed bit, set the first cycle its sync_out is 0 after reset.
  - Edges are ignored while not armed, so a strobe held high across reset release produces no command.
- UIR edge: ir_q <= ir_in.
- UDR edge: push {ir_q, sr}.
  - If the UIR and UDR edges occur in the same cycle, the push uses the pre-update ir_q.
- Latency (SYNC_STAGES=2): vs_udr first sampled high at edge k -> push at edge k+2 -> cmd_valid high after k+2 if the FIFO was empty.
- FIFO:
  - First-word-fall-through; cmd_ir and cmd_data are valid whenever cmd_valid=1.
  - Pop = cmd_valid & cmd_ready.
  - Pointers wrap modulo DEPTH.
  - level increments on push-only, decrements on pop-only, and is unchanged on push+pop.
- Full boundary:
  - A push when level==DEPTH with no pop in the same cycle is dropped.
  - A drop sets overflow=1 and increments drop_count, saturating at 2**CNT_W-1.
  - A push when full with a simultaneous pop is accepted.
- Empty boundary: cmd_ready with cmd_valid=0 has no effect and produces no pulses.
- Pop effects:
  - jdo <= cmd_data at the pop edge.
  - take_action / take_no_action are registered from the pop edge and are high for exactly one cycle.
  - At most one bit across both vectors is set in any cycle.
- clr_overflow:
  - Clears overflow and drop_count at the next edge.
  - If a drop occurs in the same cycle, the drop wins: overflow=1, drop_count=1.
- Reset mid-operation: clears the FIFO, pulses, counters and arming; a pending in-flight strobe is lost.

Test Plan:
- Reset, then ir_in=0; pulse vs_uir; sr[34]=1, sr=38'h4_0000_1234; pulse vs_udr; cmd_ready=1 -> cmd_valid rises 2 cycles after sampled vs_udr; jdo=38'h4_0000_1234; take_action=4'b0001 for one cycle.
- Same sequence with ir=2 and sr[34]=0 -> take_no_action=4'b0100 for one cycle; take_action stays 0.
- cmd_ready=0; issue 6 udr pulses (DEPTH=4) -> level=4; overflow=1; drop_count=2; popping yields the first 4 sr values in order.
- Hold cmd_ready=1 while the FIFO is full and push a 5th update -> accepted; overflow stays 0; level stays 4 for that cycle.
- Hold vs_udr=1 across reset deassertion -> no push; a subsequent low-then-high on vs_udr produces exactly one push.
- Assert clr_overflow coincident with a drop -> overflow=1, drop_count=1; assert clr_overflow alone next cycle -> both 0.
